// File: rtl/spi_xfer_pkg.sv
// Shared types and register map for the SPI transfer sequencer.
// Used by spi_xfer_ctrl and spi_wb_access.
package spi_xfer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_DIV,
        WR_SS,
        WR_TX,
        WR_GO,
        POLL,
        RD_RX,
        WR_SSCLR,
        RESP
    } state_e;

    localparam logic [4:0] ADR_TXRX = 5'h00;
    localparam logic [4:0] ADR_CTRL = 5'h10;
    localparam logic [4:0] ADR_DIV  = 5'h14;
    localparam logic [4:0] ADR_SS   = 5'h18;

    localparam int CTRL_GO  = 8;
    localparam int CTRL_IE  = 12;
    localparam int CTRL_ASS = 13;

endpackage

// File: rtl/spi_wb_access.sv
// Single-access Wishbone master: latches one request on start and holds
// cyc/stb until ack or err, releasing the bus in the following cycle.
module spi_wb_access
    import spi_xfer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [4:0]  adr,
    input  logic [31:0] wdat,
    output logic        done,
    output logic        err,
    output logic [31:0] rdat,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [4:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    always_comb begin
        cyc_d = cyc_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (cyc_q) begin
            if (wb_ack_i || wb_err_i) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                adr_d = '0;
                dat_d = '0;
            end
        end else if (start) begin
            cyc_d = 1'b1;
            we_d  = we;
            adr_d = adr;
            dat_d = wdat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
        end
    end

    assign done     = cyc_q && (wb_ack_i || wb_err_i);
    assign err      = cyc_q && wb_err_i;
    assign rdat     = wb_dat_i;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = {4{cyc_q}};
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences one SPI transfer through the core's Wishbone registers.
// Define SPI_XFER_CTRL_IRQ_WAIT_EN to wait on wb_int_i instead of polling.
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter int          SS_NB      = 8,
    parameter logic [5:0]  CTRL_FLAGS = 6'b000000,
    parameter logic [15:0] POLL_MAX   = 16'hFFFF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_tx,
    input  logic [5:0]       cmd_len,
    input  logic [SS_NB-1:0] cmd_ss,
    input  logic [15:0]      cmd_div,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rx,
    output logic             rsp_err,
    output logic [4:0]       wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_stb_o,
    output logic             wb_cyc_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_int_i
);

`ifdef SPI_XFER_CTRL_IRQ_WAIT_EN
    localparam logic IE_BIT = 1'b1;
    logic poll_rd_q, poll_rd_d;
`else
    localparam logic IE_BIT = 1'b0;
    logic unused_int;
    assign unused_int = wb_int_i;
`endif

    state_e             state_q, state_d;
    logic [31:0]        tx_q, tx_d;
    logic [5:0]         len_q, len_d;
    logic [SS_NB-1:0]   ss_q, ss_d;
    logic [15:0]        div_q, div_d;
    logic [15:0]        cache_q, cache_d;
    logic               cache_vld_q, cache_vld_d;
    logic               err_flag_q, err_flag_d;
    logic [15:0]        poll_cnt_q, poll_cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rx_q, rsp_rx_d;
    logic               start_q, start_d;
    logic               we_q, we_d;
    logic [4:0]         adr_q, adr_d;
    logic [31:0]        wdat_q, wdat_d;

    logic               acc_done, acc_err;
    logic [31:0]        acc_rdat;
    logic               issue;
    logic [31:0]        ss_ext;
    logic [31:0]        ctrl_word;

    spi_wb_access u_acc (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .start    (start_q),
        .we       (we_q),
        .adr      (adr_q),
        .wdat     (wdat_q),
        .done     (acc_done),
        .err      (acc_err),
        .rdat     (acc_rdat),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        len_d       = len_q;
        ss_d        = ss_q;
        div_d       = div_q;
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        err_flag_d  = err_flag_q;
        poll_cnt_d  = poll_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rx_d    = rsp_rx_q;
`ifdef SPI_XFER_CTRL_IRQ_WAIT_EN
        poll_rd_d   = poll_rd_q;
`endif
        issue       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tx_d       = cmd_tx;
                    len_d      = cmd_len;
                    ss_d       = cmd_ss;
                    div_d      = cmd_div;
                    err_flag_d = 1'b0;
                    rsp_err_d  = 1'b0;
                    rsp_rx_d   = '0;
                    if (cmd_len == 6'd0 || cmd_len > 6'd32) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = (cache_vld_q && cache_q == cmd_div)
                                  ? WR_SS : WR_DIV;
                    end
                end
            end
            WR_DIV: begin
                if (acc_done && !acc_err) begin
                    cache_vld_d = 1'b1;
                    cache_d     = div_q;
                    state_d     = WR_SS;
                    issue       = 1'b1;
                end
            end
            WR_SS: begin
                if (acc_done && !acc_err) begin
                    state_d = WR_TX;
                    issue   = 1'b1;
                end
            end
            WR_TX: begin
                if (acc_done && !acc_err) begin
                    state_d = WR_GO;
                    issue   = 1'b1;
                end
            end
            WR_GO: begin
                if (acc_done && !acc_err) begin
                    state_d = POLL;
`ifdef SPI_XFER_CTRL_IRQ_WAIT_EN
                    poll_cnt_d = '0;
                    poll_rd_d  = 1'b0;
`else
                    poll_cnt_d = 16'd1;
                    issue      = 1'b1;
`endif
                end
            end
            POLL: begin
`ifdef SPI_XFER_CTRL_IRQ_WAIT_EN
                // The single CTRL read after the interrupt acks it.
                if (poll_rd_q) begin
                    if (acc_done && !acc_err) begin
                        state_d = RD_RX;
                        issue   = 1'b1;
                    end
                end else if (wb_int_i) begin
                    poll_rd_d = 1'b1;
                    issue     = 1'b1;
                end else if (poll_cnt_q >= POLL_MAX) begin
                    err_flag_d = 1'b1;
                    state_d    = WR_SSCLR;
                    issue      = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                end
`else
                if (acc_done && !acc_err) begin
                    issue = 1'b1;
                    if (!acc_rdat[CTRL_GO]) begin
                        state_d = RD_RX;
                    end else if (poll_cnt_q >= POLL_MAX) begin
                        err_flag_d = 1'b1;
                        state_d    = WR_SSCLR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end
`endif
            end
            RD_RX: begin
                if (acc_done && !acc_err) begin
                    rsp_rx_d = acc_rdat;
                    state_d  = WR_SSCLR;
                    issue    = 1'b1;
                end
            end
            WR_SSCLR: begin
                if (acc_done && !acc_err) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_flag_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A failed access still deselects the slave before responding.
        if (acc_done && acc_err) begin
            err_flag_d = 1'b1;
            if (state_q == WR_SSCLR) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                issue       = 1'b0;
            end else begin
                state_d = WR_SSCLR;
                issue   = 1'b1;
            end
        end

        cmd_ready_d = (state_d == IDLE);

        ss_ext = '0;
        ss_ext[SS_NB-1:0] = ss_d;

        ctrl_word           = '0;
        ctrl_word[6:0]      = {1'b0, len_d};
        ctrl_word[CTRL_GO]  = 1'b1;
        ctrl_word[11:9]     = CTRL_FLAGS[3:1];
        ctrl_word[CTRL_IE]  = IE_BIT;
        ctrl_word[CTRL_ASS] = CTRL_FLAGS[5];

        start_d = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        wdat_d  = '0;
        if (issue) begin
            start_d = 1'b1;
            unique case (state_d)
                WR_DIV: begin
                    we_d   = 1'b1;
                    adr_d  = ADR_DIV;
                    wdat_d = {16'h0, div_d};
                end
                WR_SS: begin
                    we_d   = 1'b1;
                    adr_d  = ADR_SS;
                    wdat_d = ss_ext;
                end
                WR_TX: begin
                    we_d   = 1'b1;
                    adr_d  = ADR_TXRX;
                    wdat_d = tx_d;
                end
                WR_GO: begin
                    we_d   = 1'b1;
                    adr_d  = ADR_CTRL;
                    wdat_d = ctrl_word;
                end
                POLL:     adr_d = ADR_CTRL;
                RD_RX:    adr_d = ADR_TXRX;
                WR_SSCLR: begin
                    we_d  = 1'b1;
                    adr_d = ADR_SS;
                end
                default: start_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            len_q       <= '0;
            ss_q        <= '0;
            div_q       <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            err_flag_q  <= 1'b0;
            poll_cnt_q  <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rx_q    <= '0;
            start_q     <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
`ifdef SPI_XFER_CTRL_IRQ_WAIT_EN
            poll_rd_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            len_q       <= len_d;
            ss_q        <= ss_d;
            div_q       <= div_d;
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            err_flag_q  <= err_flag_d;
            poll_cnt_q  <= poll_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rx_q    <= rsp_rx_d;
            start_q     <= start_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
`ifdef SPI_XFER_CTRL_IRQ_WAIT_EN
            poll_rd_q   <= poll_rd_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rx    = rsp_rx_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl against a small SPI core register model.
// Expected bus accesses and responses are queued when each command is sent.
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_tx = '0;
    logic [5:0]  cmd_len = '0;
    logic [7:0]  cmd_ss = '0;
    logic [15:0] cmd_div = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rx;
    logic        rsp_err;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_int_i = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [37:0] acc_q[$];
    logic [32:0] rsp_q[$];

    logic [31:0] tx_r = '0;
    int          go_left = 0;
    logic        stuck_go = 1'b0;
    logic        inj_tx_err = 1'b0;
    int          n_cyc = 0;
    int          n_ctrl_rd = 0;
    logic        cyc_prev = 1'b0;

    spi_xfer_ctrl #(
        .SS_NB      (8),
        .CTRL_FLAGS (6'b000000),
        .POLL_MAX   (16'd3)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_tx    (cmd_tx),
        .cmd_len   (cmd_len),
        .cmd_ss    (cmd_ss),
        .cmd_div   (cmd_div),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rx    (rsp_rx),
        .rsp_err   (rsp_err),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_int_i  (wb_int_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] acc(input logic we, input logic [4:0] a,
                                        input logic [31:0] d);
        return {we, a, d};
    endfunction

    // SPI core register model with one-cycle ack at the falling edge
    always @(negedge clk) begin
        if (wb_cyc_o && !cyc_prev) n_cyc++;
        cyc_prev = wb_cyc_o;
        if (rst) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end else if (wb_ack_i || wb_err_i) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            logic [37:0] obs;
            obs = acc(wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0);
            check("sel", 64'(wb_sel_o), 64'hF);
            if (acc_q.size() == 0)
                check("acc_unexp", 64'(obs), '1);
            else
                check("acc", 64'(obs), 64'(acc_q.pop_front()));
            if (!wb_we_o && wb_adr_o == 5'h10) n_ctrl_rd++;
            wb_dat_i = '0;
            if (inj_tx_err && wb_we_o && wb_adr_o == 5'h00) begin
                inj_tx_err = 1'b0;
                wb_err_i = 1'b1;
            end else begin
                wb_ack_i = 1'b1;
                if (wb_we_o && wb_adr_o == 5'h00) tx_r = wb_dat_o;
                if (wb_we_o && wb_adr_o == 5'h10 && wb_dat_o[8]) go_left = 1;
                if (!wb_we_o && wb_adr_o == 5'h00) wb_dat_i = tx_r;
                if (!wb_we_o && wb_adr_o == 5'h10) begin
                    if (stuck_go || go_left > 0) begin
                        wb_dat_i = 32'h100;
                        if (go_left > 0) go_left--;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0)
                check("rsp_unexp", 64'({rsp_err, rsp_rx}), '1);
            else
                check("rsp", 64'({rsp_err, rsp_rx}), 64'(rsp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] tx, input logic [5:0] len,
                        input logic [7:0] ss, input logic [15:0] div);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_rdy_wait", 64'(cmd_ready), 64'h1);
        cmd_tx    = tx;
        cmd_len   = len;
        cmd_ss    = ss;
        cmd_div   = div;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(acc_q.size() == 0 && rsp_q.size() == 0 && cmd_ready)
               && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(acc_q.size() + rsp_q.size()), 64'h0);
    endtask

    task automatic exp_front(input logic [31:0] tx, input logic [5:0] len,
                             input logic [7:0] ss, input logic [15:0] div,
                             input bit wr_div);
        if (wr_div) acc_q.push_back(acc(1'b1, 5'h14, {16'h0, div}));
        acc_q.push_back(acc(1'b1, 5'h18, {24'h0, ss}));
        acc_q.push_back(acc(1'b1, 5'h00, tx));
        acc_q.push_back(acc(1'b1, 5'h10, 32'h100 | {26'h0, len}));
    endtask

    task automatic exp_normal(input logic [31:0] tx, input logic [5:0] len,
                              input logic [7:0] ss, input logic [15:0] div,
                              input bit wr_div);
        exp_front(tx, len, ss, div, wr_div);
        acc_q.push_back(acc(1'b0, 5'h10, 32'h0));
        acc_q.push_back(acc(1'b0, 5'h10, 32'h0));
        acc_q.push_back(acc(1'b0, 5'h00, 32'h0));
        acc_q.push_back(acc(1'b1, 5'h18, 32'h0));
        rsp_q.push_back({1'b0, tx});
    endtask

    initial begin
        int n;
        int c0;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        repeat (3) tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp", 64'({rsp_err, rsp_rx}), 64'h0);
        check("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'h0);
        check("rst_adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'h0);
        rst = 1'b0;
        tick();

        exp_normal(32'hA5A5_0F0F, 6'd32, 8'h01, 16'h0004, 1'b1);
        send(32'hA5A5_0F0F, 6'd32, 8'h01, 16'h0004);
        wait_done("t_wr_rd");

        exp_normal(32'h1234_5678, 6'd8, 8'h02, 16'h0004, 1'b0);
        send(32'h1234_5678, 6'd8, 8'h02, 16'h0004);
        wait_done("t_cache_hit");

        exp_normal(32'hDEAD_BEEF, 6'd1, 8'h80, 16'h0007, 1'b1);
        send(32'hDEAD_BEEF, 6'd1, 8'h80, 16'h0007);
        wait_done("t_cache_miss");

        for (int i = 0; i < 2; i++) begin
            logic [5:0] l;
            l = (i == 0) ? 6'd0 : 6'd33;
            c0 = n_cyc;
            rsp_q.push_back({1'b1, 32'h0});
            send(32'hFFFF_FFFF, l, 8'h01, 16'h0009);
            n = 0;
            while (!rsp_valid && n < 3) begin
                tick();
                n++;
            end
            check("ill_lat", 64'(n <= 2), 64'h1);
            wait_done("t_ill");
            check("ill_cyc", 64'(n_cyc), 64'(c0));
        end

        inj_tx_err = 1'b1;
        acc_q.push_back(acc(1'b1, 5'h18, 32'h04));
        acc_q.push_back(acc(1'b1, 5'h00, 32'h0BAD_0001));
        acc_q.push_back(acc(1'b1, 5'h18, 32'h0));
        rsp_q.push_back({1'b1, 32'h0});
        send(32'h0BAD_0001, 6'd16, 8'h04, 16'h0007);
        wait_done("t_buserr");

        exp_normal(32'h0F0F_5A5A, 6'd12, 8'h04, 16'h0007, 1'b0);
        send(32'h0F0F_5A5A, 6'd12, 8'h04, 16'h0007);
        wait_done("t_after_err");

        stuck_go = 1'b1;
        c0 = n_ctrl_rd;
        exp_front(32'h3333_4444, 6'd20, 8'h08, 16'h0007, 1'b0);
        repeat (3) acc_q.push_back(acc(1'b0, 5'h10, 32'h0));
        acc_q.push_back(acc(1'b1, 5'h18, 32'h0));
        rsp_q.push_back({1'b1, 32'h0});
        send(32'h3333_4444, 6'd20, 8'h08, 16'h0007);
        wait_done("t_timeout");
        check("tmo_reads", 64'(n_ctrl_rd - c0), 64'd3);
        stuck_go = 1'b0;

        rsp_ready = 1'b0;
        exp_normal(32'h5555_AAAA, 6'd24, 8'h10, 16'h0007, 1'b0);
        send(32'h5555_AAAA, 6'd24, 8'h10, 16'h0007);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(rsp_valid), 64'h1);
            check("bp_rx", 64'({rsp_err, rsp_rx}), 64'h0_5555_AAAA);
            check("bp_cmd_ready", 64'(cmd_ready), 64'h0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_done("t_backpressure");

        stuck_go = 1'b1;
        exp_front(32'h7777_0000, 6'd4, 8'h20, 16'h0007, 1'b0);
        acc_q.push_back(acc(1'b0, 5'h10, 32'h0));
        send(32'h7777_0000, 6'd4, 8'h20, 16'h0007);
        n = 0;
        while (acc_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (!wb_cyc_o && n < 20) begin
            tick();
            n++;
        end
        check("poll_busy", 64'(wb_cyc_o), 64'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_cyc", 64'({wb_cyc_o, wb_stb_o}), 64'h0);
        check("mid_rst_ready", 64'(cmd_ready), 64'h1);
        check("mid_rst_rsp", 64'(rsp_valid), 64'h0);
        stuck_go = 1'b0;
        go_left = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        exp_normal(32'hCAFE_F00D, 6'd32, 8'h01, 16'h0007, 1'b1);
        send(32'hCAFE_F00D, 6'd32, 8'h01, 16'h0007);
        wait_done("t_post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- Wishbone master sequencer for the SPI master core.
- Accepts one-word SPI transfer commands on a valid/ready port.
- Programs the core's DIVIDER, SS, TX0 and CTRL registers, waits for the transfer to finish, reads RX0, deselects the slave and returns the received word on a valid/ready response port.
- Sits between testbench/firmware-model requesters and the core's Wishbone slave port.

Parameters:
SS_NB, 8, number of slave-select lines; must match the core's SPI_SS_NB
CTRL_FLAGS, 6'b000000, static CTRL[13:8] image (ASS, IE, LSB, Tx_NEG, Rx_NEG, GO); GO and IE bits in it are ignored and driven by this block
POLL_MAX, 16'hFFFF, maximum CTRL reads while waiting for GO to clear before timeout

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_tx  in  32  transmit word
cmd_len  in  6  bits to transfer, legal 1..32
cmd_ss  in  SS_NB  slave-select mask
cmd_div  in  16  clock divider value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rx  out  32  received word
rsp_err  out  1  bus error, timeout or illegal length
wb_adr_o  out  5  core register byte address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_sel_o  out  4  always 4'hF while stb asserted, else 0
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  ack
wb_err_i  in  1  error
wb_int_i  in  1  core interrupt

Behaviour:
- Clock is wb_clk_i. Reset is wb_rst_i, asynchronous, active-high.
- Reset values:
  - All outputs 0 except cmd_ready = 1.
  - State IDLE.
  - Divider cache invalid.
- Register addresses: TX0/RX0 = 5'h00, CTRL = 5'h10, DIVIDER = 5'h14, SS = 5'h18.
- States: IDLE, WR_DIV, WR_SS, WR_TX, WR_GO, POLL, RD_RX, WR_SSCLR, RESP.
- IDLE:
  - cmd_ready = 1. Command fields are latched on handshake.
  - cmd_len == 0 or > 32: go straight to RESP with rsp_err = 1, rsp_rx = 0, no bus traffic.
  - Otherwise go to WR_DIV, or to WR_SS if the cache is valid and equals cmd_div.
- Each bus state:
  - cyc = stb = 1 with address, data and we registered on state entry.
  - Held until wb_ack_i or wb_err_i; minimum one cycle per access, no pipelining.
  - Drops cyc/stb in the cycle after the ack.
- wb_err_i on any access:
  - Sets a sticky error flag.
  - Goes to WR_SSCLR; if the erroring access was WR_SSCLR itself, goes to RESP.
- WR_DIV: writes {16'h0, div}, then marks the cache valid with that value.
- WR_SS: writes the zero-extended SS mask.
- WR_TX: writes cmd_tx.
- WR_GO: writes {18'h0, CTRL_FLAGS[5] (ASS), IE, CTRL_FLAGS[3:1], GO=1, 1'b0, len[6:0]}.
  - len = 32 is encoded as 7'd32.
  - IE = 0 unless the optional feature is enabled.
- POLL: reads CTRL.
  - GO (bit 8) == 0: go to RD_RX.
  - Otherwise re-read.
  - After POLL_MAX reads with GO still set: set the error flag (timeout) and go to WR_SSCLR.
- RD_RX: reads RX0 and captures the value into rsp_rx.
- WR_SSCLR: writes 0 to SS.
- RESP:
  - rsp_valid = 1 with rsp_rx and rsp_err stable until rsp_ready.
  - Then back to IDLE.
  - rsp_valid and rsp_ready may both be high on the first RESP cycle.
- cmd_ready = 0 in every state except IDLE.
- A command and a response are never outstanding simultaneously.
- A reset mid-transaction drops cyc/stb immediately, invalidates the cache and discards the response.

Optional Feature:
- Macro SPI_XFER_CTRL_IRQ_WAIT_EN.
- Defined:
  - WR_GO sets IE = 1.
  - POLL issues no reads; it idles with cyc = 0 until wb_int_i = 1.
  - It then performs one CTRL read, which clears the interrupt, and proceeds to RD_RX.
  - The timeout counts idle cycles against POLL_MAX.
- Undefined: polling as described above; wb_int_i is ignored.

Decomposition:
- Package spi_xfer_pkg holds:
  - state enum state_e;
  - register address localparams ADR_TXRX, ADR_CTRL, ADR_DIV, ADR_SS;
  - CTRL bit index constants CTRL_GO = 8, CTRL_IE = 12, CTRL_ASS = 13.
- One sub-module, spi_wb_access: single-access Wishbone master engine (start, we, adr, wdat → done, err, rdat), instanced once; the FSM in spi_xfer_ctrl drives it.

Test Plan:
- Write–read order and values:
  - Stimulus: cmd tx = 32'hA5A5_0F0F, len = 32, ss = 8'h01, div = 16'h0004, slave model loops MOSI to MISO.
  - Required: bus writes DIV = 4, SS = 1, TX = A5A50F0F, CTRL = 0x120 (GO set, length 32 encoded), polls, reads RX, writes SS = 0; rsp_rx = A5A50F0F, rsp_err = 0.
- Divider cache: a second cmd with the same div = 4 → no DIVIDER write. A third cmd with div = 7 → DIVIDER write of 7.
- Illegal lengths: cmd_len = 0 and cmd_len = 33 → rsp_err = 1 within 2 cycles, zero wb_cyc_o assertions.
- Bus error: wb_err_i on the WR_TX access → next access is SS = 0, then rsp_err = 1; the following valid cmd completes normally.
- Timeout and backpressure:
  - POLL_MAX = 3 with GO stuck at 1 → exactly 3 CTRL reads, SS cleared, rsp_err = 1.
  - rsp_ready held low for 10 cycles → rsp_valid and rsp_rx stable, cmd_ready = 0 throughout.
- Reset mid-poll: assert wb_rst_i during POLL → same cycle wb_cyc_o = 0, cmd_ready = 1, rsp_valid = 0. The next cmd rewrites DIVIDER.
